aes_req_scheduler: RTL and testbench
====================================

Name: aes_req_scheduler

Overview:
- Round-robin scheduler that shares one reduced-AES engine (start/done handshake, 128-bit plaintext, KEY_SIZE key) among NUM_REQ requesters.
- Accepts a request, sequences the engine (load, start, wait, capture) and returns the ciphertext tagged with the requester ID.
- A watchdog aborts any job whose engine never signals done.
- Sits between requester ports and the AES core in the host.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- KEY_SIZE, 64, AES key width; must match the engine
- TIMEOUT, 32, maximum BUSY cycles before abort (>=8)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept pulse, one-hot or zero
- req_plaintext  in  NUM_REQ*128  packed plaintexts; requester i at [i*128 +: 128]
- req_key  in  NUM_REQ*KEY_SIZE  packed keys; requester i at [i*KEY_SIZE +: KEY_SIZE]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  $clog2(NUM_REQ)  requester index of the response
- rsp_data  out  128  ciphertext; 0 on error
- rsp_err  out  1  job aborted by watchdog
- aes_start  out  1  engine start, one-cycle pulse
- aes_plaintext  out  128  engine plaintext
- aes_key  out  KEY_SIZE  engine key
- aes_done  in  1  engine done pulse
- aes_ciphertext  in  128  engine output, valid the cycle after aes_done
- busy  out  1  high in any state other than IDLE
- err_count  out  8  saturating count of watchdog aborts

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; round-robin pointer = 0, so requester 0 has highest priority first; err_count = 0.
- States: IDLE, LOAD, START, BUSY, CAPTURE, RESP.
- IDLE:
  - If any req_valid is set, grant the first valid index at or after ptr (wrapping).
  - Pulse req_ready[g] for that cycle only.
  - Latch plaintext, key and ID.
  - Set ptr = (g+1) mod NUM_REQ.
  - Go to LOAD.
- LOAD: drive aes_plaintext/aes_key from the latches, aes_start=0; lasts one cycle; go to START.
- START: aes_start=1 for exactly one cycle; clear the watchdog counter; go to BUSY.
- BUSY:
  - On aes_done=1: go to CAPTURE.
  - Otherwise increment the watchdog. When it reaches TIMEOUT-1 without done: rsp_err=1, rsp_data=0, err_count++ (saturate at 255), go to RESP.
- CAPTURE: register aes_ciphertext into rsp_data (the cycle after done); rsp_err=0; go to RESP.
- RESP:
  - rsp_valid=1; rsp_id/rsp_data/rsp_err held stable.
  - On rsp_valid && rsp_ready: clear rsp_valid and go to IDLE.
  - No new grant while in RESP.
- Engine inputs: aes_plaintext/aes_key hold the latched values from LOAD until leaving BUSY/CAPTURE. They are 0 in IDLE.
- Latency: grant at cycle t, aes_start at t+2. If done is seen at D, rsp_valid rises at D+2. Next grant is no earlier than the cycle after the response handshake.
- req_valid deasserting without a grant drops that request silently; requesters hold request data until they see req_ready.
- aes_done outside BUSY is ignored.
- A req_valid change during a job has no effect on the current job.
- Reset mid-operation aborts immediately: no response and no error count. The engine is reset by the same rst_n.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0.

Test Plan:
- Single request: req_valid=4'b0100, pt=128'h00112233445566778899AABBCCDDEEFF, key=64'h0F1E2D3C4B5A6978. Expect req_ready[2] for one cycle, aes_start two cycles later, then rsp_valid with rsp_id=2, rsp_err=0 and rsp_data equal to the engine model's output, 2 cycles after aes_done.
- Round-robin: all four req_valid held high, rsp_ready=1. Expect grant order 0,1,2,3,0,1 and exactly one aes_start per job.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid. Expect rsp_valid/rsp_id/rsp_data stable, no req_ready pulses and busy=1. Release: handshake completes, then the next grant.
- Watchdog: stub engine never asserts done, TIMEOUT=32. Expect rsp_err=1, rsp_data=0 and err_count=1 after 32 BUSY cycles. Repeat 256 times and expect err_count to saturate at 255.
- Reset mid-BUSY: drop rst_n asynchronously. Expect all outputs 0 immediately, ptr=0, no response; a new request after release is served normally.
- Spurious done: pulse aes_done while IDLE. Expect no state change and no rsp_valid.

Source files
------------

// File: rtl/aes_req_scheduler.sv
// rtl/aes_req_scheduler.sv - round-robin scheduler sharing one AES engine among NUM_REQ requesters
module aes_req_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int KEY_SIZE = 64,
    parameter int TIMEOUT  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*128-1:0]      req_plaintext,
    input  logic [NUM_REQ*KEY_SIZE-1:0] req_key,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [127:0]                rsp_data,
    output logic                        rsp_err,
    output logic                        aes_start,
    output logic [127:0]                aes_plaintext,
    output logic [KEY_SIZE-1:0]         aes_key,
    input  logic                        aes_done,
    input  logic [127:0]                aes_ciphertext,
    output logic                        busy,
    output logic [7:0]                  err_count
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_BUSY    = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    logic [2:0]          state;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     job_id;
    logic [ID_W-1:0]     grant_idx;
    logic [ID_W-1:0]     cand;
    logic                grant_any;
    logic [127:0]        pt_q;
    logic [KEY_SIZE-1:0] key_q;
    logic [WD_W-1:0]     wdog;
    logic                engine_drive;

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Gated by rst_n so no accept pulse escapes while reset is held.
    assign req_ready = (state == S_IDLE && grant_any && rst_n)
                       ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;

    assign engine_drive  = (state == S_LOAD) || (state == S_START) ||
                           (state == S_BUSY) || (state == S_CAPTURE);
    assign aes_plaintext = engine_drive ? pt_q  : '0;
    assign aes_key       = engine_drive ? key_q : '0;
    assign aes_start     = (state == S_START);
    assign rsp_valid     = (state == S_RESP);
    assign rsp_id        = job_id;
    assign busy          = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            job_id    <= '0;
            pt_q      <= '0;
            key_q     <= '0;
            wdog      <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            err_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        job_id <= grant_idx;
                        pt_q   <= req_plaintext[int'(grant_idx)*128 +: 128];
                        key_q  <= req_key[int'(grant_idx)*KEY_SIZE +: KEY_SIZE];
                        ptr    <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: state <= S_START;
                S_START: begin
                    wdog  <= '0;
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    if (aes_done) begin
                        state <= S_CAPTURE;
                    end else if (wdog == WD_W'(TIMEOUT-1)) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                        state <= S_RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                // Ciphertext is only valid the cycle after done.
                S_CAPTURE: begin
                    rsp_data <= aes_ciphertext;
                    rsp_err  <= 1'b0;
                    state    <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_req_scheduler.sv
// tb/tb_aes_req_scheduler.sv - self-checking bench for aes_req_scheduler with a stub AES engine
module tb_aes_req_scheduler;
    localparam int N   = 4;
    localparam int KS  = 64;
    localparam int TO  = 32;
    localparam int IDW = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*128-1:0]   req_plaintext;
    logic [N*KS-1:0]    req_key;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [127:0]       rsp_data;
    logic               rsp_err;
    logic               aes_start;
    logic [127:0]       aes_plaintext;
    logic [KS-1:0]      aes_key;
    logic               aes_done;
    logic [127:0]       aes_ciphertext;
    logic               busy;
    logic [7:0]         err_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ref_ptr = 0;

    logic [127:0] pts [N];
    logic [KS-1:0] keys [N];

    aes_req_scheduler #(.NUM_REQ(N), .KEY_SIZE(KS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_plaintext(req_plaintext), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .aes_start(aes_start), .aes_plaintext(aes_plaintext), .aes_key(aes_key),
        .aes_done(aes_done), .aes_ciphertext(aes_ciphertext),
        .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the reduced AES core.
    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [KS-1:0] k);
        return {pt[63:0], pt[127:64]} ^ {k, ~k} ^ 128'h5A5A_C3C3_0F0F_9696_A5A5_3C3C_F0F0_6969;
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    logic          eng_done;
    logic          spur_done = 1'b0;
    logic          eng_busy;
    int            eng_cnt;
    int            eng_lat = 2;
    bit            eng_hang = 1'b0;
    logic [127:0]  eng_pt;
    logic [KS-1:0] eng_key;

    assign aes_done = eng_done | spur_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_done       <= 1'b0;
            eng_busy       <= 1'b0;
            eng_cnt        <= 0;
            aes_ciphertext <= '0;
        end else begin
            eng_done <= 1'b0;
            if (eng_done) aes_ciphertext <= aes_model(eng_pt, eng_key);
            if (aes_start) begin
                eng_busy <= 1'b1;
                eng_cnt  <= eng_lat;
                eng_pt   <= aes_plaintext;
                eng_key  <= aes_key;
            end else if (eng_busy && !eng_hang) begin
                if (eng_cnt == 0) begin
                    eng_done <= 1'b1;
                    eng_busy <= 1'b0;
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end
        end
    end

    task automatic pack_inputs();
        for (int i = 0; i < N; i++) begin
            req_plaintext[i*128 +: 128] = pts[i];
            req_key[i*KS +: KS]         = keys[i];
        end
    endtask

    task automatic new_data(input int i);
        pts[i]  = {$urandom, $urandom, $urandom, $urandom};
        keys[i] = {$urandom, $urandom};
        pack_inputs();
    endtask

    int            jg, jnready, jt_grant, jt_start, jnstart, jt_done, jt_rsp, jt_hs;
    logic [127:0]  jpt, jdata;
    logic [KS-1:0] jkey;
    logic          jerr;
    logic [IDW-1:0] jid;
    bit            jbp_bad, jonehot_bad;

    // Runs one job to its response handshake, recording what was observed.
    task automatic do_job(input logic [N-1:0] valid, input bit drop, input int bp);
        int held;
        bit fin;
        jg = -1; jnready = 0; jt_grant = -1; jt_start = -1; jnstart = 0;
        jt_done = -1; jt_rsp = -1; jt_hs = -1;
        jpt = '0; jkey = '0; jdata = '0; jerr = 1'b0; jid = '0;
        jbp_bad = 1'b0; jonehot_bad = 1'b0; held = 0; fin = 1'b0;
        @(posedge clk); #1;
        req_valid = valid;
        rsp_ready = (bp == 0);
        for (int n = 0; n < 400 && !fin; n++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                jnready++;
                if ($countones(req_ready) != 1) jonehot_bad = 1'b1;
                if (jt_grant < 0) begin
                    jt_grant = cyc;
                    for (int i = 0; i < N; i++) if (req_ready[i]) jg = i;
                end
            end
            if (aes_start) begin
                jnstart++;
                if (jt_start < 0) begin
                    jt_start = cyc;
                    jpt = aes_plaintext;
                    jkey = aes_key;
                end
            end
            if (aes_done && jt_start >= 0 && jt_done < 0) jt_done = cyc;
            if (rsp_valid && jt_rsp < 0) begin
                jt_rsp = cyc;
                jdata = rsp_data;
                jid = rsp_id;
                jerr = rsp_err;
            end
            if (rsp_valid && (rsp_data !== jdata || rsp_id !== jid || rsp_err !== jerr ||
                              !busy || req_ready != '0))
                jbp_bad = 1'b1;
            if (rsp_valid && rsp_ready) begin
                jt_hs = cyc;
                fin = 1'b1;
            end else begin
                @(posedge clk); #1;
                if (drop && jg >= 0) req_valid[jg] = 1'b0;
                if (jt_rsp >= 0) begin
                    held++;
                    if (held >= bp) rsp_ready = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        req_valid = '1;
        #12;
        checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        checks++; if ({rsp_valid, busy, aes_start, rsp_err} !== 4'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=0", {rsp_valid, busy, aes_start, rsp_err}); end
        checks++; if ({aes_plaintext, aes_key} !== '0) begin failures++; $display("FAIL reset_engine_in got=%0h exp=0", {aes_plaintext, aes_key}); end
        checks++; if ({rsp_data, rsp_id, err_count} !== '0) begin failures++; $display("FAIL reset_rsp got=%0h exp=0", {rsp_data, rsp_id, err_count}); end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        ref_ptr = 0;
    endtask

    task automatic test_round_robin();
        int exp_g;
        int prev_hs;
        prev_hs = -1;
        for (int j = 0; j < 6; j++) begin
            eng_lat = $urandom_range(0, 8);
            exp_g = pick(4'b1111, ref_ptr);
            do_job(4'b1111, 1'b0, 0);
            checks++; if (jg != exp_g) begin failures++; $display("FAIL rr_grant job=%0d got=%0d exp=%0d", j, jg, exp_g); end
            checks++; if (jnready != 1 || jonehot_bad) begin failures++; $display("FAIL rr_ready_pulses job=%0d got=%0d exp=1", j, jnready); end
            checks++; if (jnstart != 1) begin failures++; $display("FAIL rr_start_count job=%0d got=%0d exp=1", j, jnstart); end
            checks++; if (jt_start != jt_grant + 2) begin failures++; $display("FAIL rr_start_lat job=%0d got=%0d exp=%0d", j, jt_start, jt_grant + 2); end
            checks++; if (jt_rsp != jt_done + 2) begin failures++; $display("FAIL rr_rsp_lat job=%0d got=%0d exp=%0d", j, jt_rsp, jt_done + 2); end
            checks++; if (jdata !== aes_model(pts[exp_g], keys[exp_g]) || jerr !== 1'b0 || jid !== IDW'(exp_g)) begin
                failures++; $display("FAIL rr_rsp job=%0d got=%0h/%0d/%0b exp=%0h/%0d/0", j, jdata, jid, jerr, aes_model(pts[exp_g], keys[exp_g]), exp_g);
            end
            if (prev_hs >= 0) begin
                checks++; if (jt_grant != prev_hs + 1) begin failures++; $display("FAIL rr_next_grant job=%0d got=%0d exp=%0d", j, jt_grant, prev_hs + 1); end
            end
            prev_hs = jt_hs;
            ref_ptr = (exp_g + 1) % N;
            new_data(exp_g);
        end
    endtask

    task automatic test_single();
        pts[2]  = 128'h00112233445566778899AABBCCDDEEFF;
        keys[2] = 64'h0F1E2D3C4B5A6978;
        pack_inputs();
        eng_lat = 3;
        do_job(4'b0100, 1'b1, 0);
        checks++; if (jg != 2 || jnready != 1) begin failures++; $display("FAIL single_grant got=%0d/%0d exp=2/1", jg, jnready); end
        checks++; if (jt_start != jt_grant + 2) begin failures++; $display("FAIL single_start_lat got=%0d exp=%0d", jt_start, jt_grant + 2); end
        checks++; if (jpt !== pts[2] || jkey !== keys[2]) begin failures++; $display("FAIL single_engine_in got=%0h/%0h exp=%0h/%0h", jpt, jkey, pts[2], keys[2]); end
        checks++; if (jt_rsp != jt_done + 2) begin failures++; $display("FAIL single_rsp_lat got=%0d exp=%0d", jt_rsp, jt_done + 2); end
        checks++; if (jdata !== aes_model(pts[2], keys[2]) || jerr !== 1'b0 || jid !== 2'd2) begin
            failures++; $display("FAIL single_rsp got=%0h/%0d/%0b exp=%0h/2/0", jdata, jid, jerr, aes_model(pts[2], keys[2]));
        end
        ref_ptr = 3;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || aes_plaintext !== '0) begin failures++; $display("FAIL single_idle got=%0b/%0h exp=0/0", busy, aes_plaintext); end
    endtask

    task automatic test_spurious_done();
        bit bad;
        bad = 1'b0;
        @(posedge clk); #1 spur_done = 1'b1;
        @(posedge clk); #1 spur_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (busy || rsp_valid || req_ready != '0) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL spurious_done got=activity exp=idle"); end
    endtask

    task automatic test_backpressure();
        int exp_g;
        int hs;
        eng_lat = $urandom_range(0, 6);
        exp_g = pick(4'b1111, ref_ptr);
        do_job(4'b1111, 1'b0, 10);
        checks++; if (jbp_bad) begin failures++; $display("FAIL bp_stable got=changed exp=stable"); end
        checks++; if (jt_hs != jt_rsp + 10) begin failures++; $display("FAIL bp_hs_time got=%0d exp=%0d", jt_hs, jt_rsp + 10); end
        checks++; if (jdata !== aes_model(pts[exp_g], keys[exp_g]) || jid !== IDW'(exp_g)) begin
            failures++; $display("FAIL bp_rsp got=%0h/%0d exp=%0h/%0d", jdata, jid, aes_model(pts[exp_g], keys[exp_g]), exp_g);
        end
        ref_ptr = (exp_g + 1) % N;
        new_data(exp_g);
        hs = jt_hs;
        exp_g = pick(4'b1111, ref_ptr);
        do_job(4'b1111, 1'b0, 0);
        checks++; if (jt_grant != hs + 1 || jg != exp_g) begin failures++; $display("FAIL bp_next_grant got=%0d@%0d exp=%0d@%0d", jg, jt_grant, exp_g, hs + 1); end
        ref_ptr = (exp_g + 1) % N;
        new_data(exp_g);
    endtask

    task automatic test_reset_mid_busy();
        bit seen;
        bit bad;
        eng_lat = 20;
        @(posedge clk); #1 req_valid = 4'b0010;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (req_ready[1]) seen = 1'b1;
        end
        @(posedge clk); #1 req_valid = '0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (aes_start) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL rst_job_start got=none exp=aes_start"); end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== '0 || {rsp_valid, busy, aes_start, rsp_err} !== 4'b0) begin
            failures++; $display("FAIL rst_async_ctrl got=%b/%b exp=0/0", req_ready, {rsp_valid, busy, aes_start, rsp_err});
        end
        checks++; if ({aes_plaintext, aes_key} !== '0) begin failures++; $display("FAIL rst_async_engine got=%0h exp=0", {aes_plaintext, aes_key}); end
        checks++; if ({rsp_data, rsp_id, err_count} !== '0) begin failures++; $display("FAIL rst_async_rsp got=%0h exp=0", {rsp_data, rsp_id, err_count}); end
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_ptr = 0;
        bad = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid || busy) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL rst_no_response got=activity exp=idle"); end
        eng_lat = 4;
        do_job(4'b1111, 1'b0, 0);
        checks++; if (jg != 0) begin failures++; $display("FAIL rst_ptr_grant got=%0d exp=0", jg); end
        checks++; if (jdata !== aes_model(pts[0], keys[0]) || jerr !== 1'b0 || err_count !== 8'd0) begin
            failures++; $display("FAIL rst_after_job got=%0h/%0b/%0d exp=%0h/0/0", jdata, jerr, err_count, aes_model(pts[0], keys[0]));
        end
        ref_ptr = 1;
        new_data(0);
    endtask

    task automatic test_watchdog();
        int exp_g;
        int exp_ec;
        eng_hang = 1'b1;
        exp_ec = 0;
        for (int k = 1; k <= 256; k++) begin
            exp_g = pick(4'b1111, ref_ptr);
            do_job(4'b1111, 1'b0, 0);
            if (exp_ec < 255) exp_ec++;
            checks++; if (jerr !== 1'b1 || jdata !== '0 || jid !== IDW'(exp_g)) begin
                failures++; $display("FAIL wd_rsp job=%0d got=%0b/%0h/%0d exp=1/0/%0d", k, jerr, jdata, jid, exp_g);
            end
            checks++; if (err_count !== 8'(exp_ec)) begin failures++; $display("FAIL wd_err_count job=%0d got=%0d exp=%0d", k, err_count, exp_ec); end
            if (k == 1) begin
                checks++; if (jt_rsp != jt_start + TO + 1) begin failures++; $display("FAIL wd_timeout_lat got=%0d exp=%0d", jt_rsp, jt_start + TO + 1); end
            end
            ref_ptr = (exp_g + 1) % N;
        end
        eng_hang = 1'b0;
        eng_lat = 5;
        exp_g = pick(4'b1111, ref_ptr);
        do_job(4'b1111, 1'b0, 0);
        checks++; if (jerr !== 1'b0 || jdata !== aes_model(pts[exp_g], keys[exp_g]) || err_count !== 8'd255) begin
            failures++; $display("FAIL wd_recover got=%0b/%0h/%0d exp=0/%0h/255", jerr, jdata, err_count, aes_model(pts[exp_g], keys[exp_g]));
        end
        ref_ptr = (exp_g + 1) % N;
    endtask

    initial begin
        req_valid = '0;
        rsp_ready = 1'b0;
        req_plaintext = '0;
        req_key = '0;
        for (int i = 0; i < N; i++) new_data(i);
        test_reset();
        test_round_robin();
        test_single();
        test_spurious_done();
        test_backpressure();
        test_reset_mid_busy();
        test_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
